// File: rtl/savestate_controller_pkg.sv
// Shared types for the savestate initiator: FSM state and operation encodings,
// plus a helper that sizes small terminal-count counters.
package savestate_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT_WAIT,
    ST_SAVE_ADDR,
    ST_SAVE_WAIT,
    ST_SAVE_OUT,
    ST_LOAD_WAIT,
    ST_LOAD_WRITE,
    ST_FINISH
  } ss_state_t;

  typedef enum logic {
    SS_OP_SAVE,
    SS_OP_LOAD
  } ss_op_t;

  localparam int SS_WORD_W = 32;

  // Bits needed to hold 0..terminal (at least one bit).
  function automatic int ss_cnt_width(input int terminal);
    return (terminal < 1) ? 1 : $clog2(terminal + 1);
  endfunction

endpackage

// File: rtl/ss_timeout_counter.sv
// Saturating up-counter with synchronous clear and enable. tc is high while
// the count sits at TERMINAL; the count never moves past it.
module ss_timeout_counter
  import savestate_controller_pkg::*;
#(
  parameter int TERMINAL = 4095
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = ss_cnt_width(TERMINAL);
  localparam logic [CW-1:0] TC_VAL = CW'(TERMINAL);

  logic [CW-1:0] count;

  // Count up while enabled, hold at the terminal value, clear on request.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en && (count != TC_VAL)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/savestate_controller.sv
// Savestate bus initiator: halts the core, then either streams NUM_WORDS
// state words out to the host (save) or writes host words into the core (load).
module savestate_controller
  import savestate_controller_pkg::*;
#(
  parameter int NUM_WORDS    = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int HALT_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  save_start,
  input  logic                  load_start,
  output logic [31:0]           host_rd_data,
  output logic                  host_rd_valid,
  input  logic                  host_rd_ready,
  input  logic [31:0]           host_wr_data,
  input  logic                  host_wr_valid,
  output logic                  host_wr_ready,
  output logic                  ss_halt,
  input  logic                  ss_ready,
  output logic [ADDR_WIDTH-1:0] ss_bus_addr,
  output logic [31:0]           ss_bus_in,
  output logic                  ss_bus_wren,
  output logic                  ss_bus_reset_n,
  input  logic [31:0]           ss_bus_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

  ss_state_t state_q, state_d;
  ss_op_t    op_q, op_d;

  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           bus_in_q;
  logic [31:0]           rd_data_q;
  logic                  error_q;

  logic op_ld;
  logic cnt_clr;
  logic sv_next;
  logic ld_next;
  logic rd_cap;
  logic wr_lat;
  logic tmo;
  logic is_last;

  logic halt_clr, halt_en, halt_tc;
  logic lat_clr, lat_en, lat_tc;

  assign is_last = (cnt_q == LAST_IDX);

  assign halt_en  = (state_q == ST_HALT_WAIT);
  assign halt_clr = !halt_en;
  assign lat_en   = (state_q == ST_SAVE_WAIT);
  assign lat_clr  = !lat_en;

  // Cycles spent waiting for the core to acknowledge the halt request.
  ss_timeout_counter #(.TERMINAL(HALT_TIMEOUT - 1)) u_halt_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (halt_clr),
    .en    (halt_en),
    .tc    (halt_tc)
  );

  // Responder read latency; the address is already driven during SAVE_ADDR,
  // so READ_LATENCY cycles of SAVE_WAIT land exactly on valid read data.
  ss_timeout_counter #(.TERMINAL(READ_LATENCY - 1)) u_lat_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (lat_clr),
    .en    (lat_en),
    .tc    (lat_tc)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the datapath strobes that go with each transition.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    op_ld   = 1'b0;
    cnt_clr = 1'b0;
    sv_next = 1'b0;
    ld_next = 1'b0;
    rd_cap  = 1'b0;
    wr_lat  = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (save_start) begin
          op_d    = SS_OP_SAVE;
          op_ld   = 1'b1;
          state_d = ST_HALT_WAIT;
        end else if (load_start) begin
          op_d    = SS_OP_LOAD;
          op_ld   = 1'b1;
          state_d = ST_HALT_WAIT;
        end
      end
      ST_HALT_WAIT: begin
        if (ss_ready) begin
          cnt_clr = 1'b1;
          state_d = (op_q == SS_OP_SAVE) ? ST_SAVE_ADDR : ST_LOAD_WAIT;
        end else if (halt_tc) begin
          tmo     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_SAVE_ADDR: begin
        state_d = ST_SAVE_WAIT;
      end
      ST_SAVE_WAIT: begin
        if (lat_tc) begin
          rd_cap  = 1'b1;
          state_d = ST_SAVE_OUT;
        end
      end
      ST_SAVE_OUT: begin
        if (host_rd_ready) begin
          if (is_last) begin
            state_d = ST_FINISH;
          end else begin
            sv_next = 1'b1;
            state_d = ST_SAVE_ADDR;
          end
        end
      end
      ST_LOAD_WAIT: begin
        if (host_wr_valid) begin
          wr_lat  = 1'b1;
          state_d = ST_LOAD_WRITE;
        end
      end
      ST_LOAD_WRITE: begin
        if (is_last) begin
          state_d = ST_FINISH;
        end else begin
          ld_next = 1'b1;
          state_d = ST_LOAD_WAIT;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Word counter, bus address/data, captured read word and the error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= SS_OP_SAVE;
      cnt_q     <= '0;
      addr_q    <= '0;
      bus_in_q  <= '0;
      rd_data_q <= '0;
      error_q   <= 1'b0;
    end else begin
      error_q <= tmo;
      if (op_ld) begin
        op_q <= op_d;
      end
      if (cnt_clr) begin
        cnt_q  <= '0;
        addr_q <= '0;
      end
      if (sv_next) begin
        cnt_q  <= cnt_q + 1'b1;
        addr_q <= cnt_q + 1'b1;
      end
      if (ld_next) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (wr_lat) begin
        bus_in_q <= host_wr_data;
        addr_q   <= cnt_q;
      end
      if (rd_cap) begin
        rd_data_q <= ss_bus_out;
      end
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign ss_halt        = busy;
  assign host_rd_valid  = (state_q == ST_SAVE_OUT);
  assign host_wr_ready  = (state_q == ST_LOAD_WAIT);
  assign ss_bus_wren    = (state_q == ST_LOAD_WRITE);
  assign done           = (state_q == ST_FINISH);
  assign error          = error_q;
  assign ss_bus_reset_n = !((state_q == ST_HALT_WAIT) && ss_ready && (op_q == SS_OP_LOAD));
  assign ss_bus_addr    = addr_q;
  assign ss_bus_in      = bus_in_q;
  assign host_rd_data   = rd_data_q;

endmodule

// File: tb/tb_savestate_controller.sv
// Bench for savestate_controller: core/responder model, host drivers, and a
// queue-based scoreboard whose monitor checks every host read and bus write.
module tb_savestate_controller;

  localparam int NW = 4;
  localparam int AW = 8;
  localparam int RL = 2;
  localparam int HT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          save_start = 1'b0;
  logic          load_start = 1'b0;
  logic [31:0]   host_rd_data;
  logic          host_rd_valid;
  logic          host_rd_ready = 1'b0;
  logic [31:0]   host_wr_data = 32'd0;
  logic          host_wr_valid = 1'b0;
  logic          host_wr_ready;
  logic          ss_halt;
  logic          ss_ready = 1'b0;
  logic [AW-1:0] ss_bus_addr;
  logic [31:0]   ss_bus_in;
  logic          ss_bus_wren;
  logic          ss_bus_reset_n;
  logic [31:0]   ss_bus_out;
  logic          busy;
  logic          done;
  logic          error;

  savestate_controller #(
    .NUM_WORDS(NW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .HALT_TIMEOUT(HT)
  ) dut (
    .clk(clk), .reset(reset), .save_start(save_start), .load_start(load_start),
    .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
    .host_wr_data(host_wr_data), .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .ss_halt(ss_halt), .ss_ready(ss_ready), .ss_bus_addr(ss_bus_addr), .ss_bus_in(ss_bus_in),
    .ss_bus_wren(ss_bus_wren), .ss_bus_reset_n(ss_bus_reset_n), .ss_bus_out(ss_bus_out),
    .busy(busy), .done(done), .error(error)
  );

  int checks = 0;
  int failures = 0;

  task automatic ck1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic ck32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic ckint(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Core model: state memory read with RL cycles of latency, writes captured separately.
  logic [31:0] mem  [256];
  logic [31:0] wmem [256];
  logic [31:0] rd_pipe [RL];
  int          halt_cyc = 0;
  bit          ready_en = 1'b1;

  // Core acknowledges the halt three cycles after it is requested.
  always @(posedge clk) begin
    if (ss_halt !== 1'b1) begin
      halt_cyc <= 0;
      ss_ready <= 1'b0;
    end else begin
      halt_cyc <= halt_cyc + 1;
      ss_ready <= ready_en && (halt_cyc >= 2);
    end
  end

  // Registered read pipeline and write capture of the responders.
  always @(posedge clk) begin
    rd_pipe[0] <= mem[ss_bus_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (ss_bus_wren === 1'b1) wmem[ss_bus_addr] <= ss_bus_in;
  end
  assign ss_bus_out = rd_pipe[RL-1];

  // Scoreboard queues and monitor state.
  logic [31:0]    exp_rd [$];
  logic [AW+31:0] exp_wr [$];
  int  done_cnt = 0, err_cnt = 0, wren_cnt = 0, rstn_cnt = 0, rd_cnt = 0;
  bit  rstn_seen = 1'b0;
  bit  prev_wren = 1'b0;
  bit  prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;

  // Host read-ready driver: always-ready or random, with an optional forced
  // stall of five valid cycles on one chosen word.
  int  rd_mode = 0;
  int  stall_word = -1;
  int  stall_left = 0;
  int  rd_base = 0;
  always begin
    @(posedge clk);
    #1;
    if (stall_left > 0 && (rd_cnt - rd_base) == stall_word) begin
      host_rd_ready = 1'b0;
      if (host_rd_valid === 1'b1) stall_left--;
    end else begin
      host_rd_ready = (rd_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: pops the expected response whenever the DUT presents one.
  always @(negedge clk) begin
    logic [AW+31:0] item;
    if (host_rd_valid === 1'b1) begin
      if (prev_stall) ck32("rd_data_stable", host_rd_data, prev_data);
      if (host_rd_ready) begin
        rd_cnt++;
        if (exp_rd.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_word got=%h want=<no word expected>", host_rd_data);
        end else begin
          ck32("rd_word", host_rd_data, exp_rd.pop_front());
        end
      end
      prev_stall = !host_rd_ready;
      prev_data  = host_rd_data;
    end else begin
      prev_stall = 1'b0;
    end
    if (ss_bus_wren === 1'b1) begin
      wren_cnt++;
      ck1("wren_single_cycle", prev_wren, 1'b0);
      ck1("bus_reset_before_write", rstn_seen, 1'b1);
      if (exp_wr.size() == 0) begin
        checks++; failures++;
        $display("FAIL bus_write got=%h@%h want=<no write expected>", ss_bus_in, ss_bus_addr);
      end else begin
        item = exp_wr.pop_front();
        ckint("wr_addr", int'(ss_bus_addr), int'(item[AW+31:32]));
        ck32("wr_data", ss_bus_in, item[31:0]);
      end
    end
    prev_wren = (ss_bus_wren === 1'b1);
    if (ss_bus_reset_n === 1'b0) begin
      rstn_cnt++;
      rstn_seen = 1'b1;
    end
    if (done === 1'b1) done_cnt++;
    if (error === 1'b1) err_cnt++;
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    ck1({tag, "_ss_halt"}, ss_halt, 1'b0);
    ckint({tag, "_ss_bus_addr"}, int'(ss_bus_addr), 0);
    ck32({tag, "_ss_bus_in"}, ss_bus_in, 32'd0);
    ck1({tag, "_ss_bus_wren"}, ss_bus_wren, 1'b0);
    ck1({tag, "_ss_bus_reset_n"}, ss_bus_reset_n, 1'b1);
    ck1({tag, "_host_rd_valid"}, host_rd_valid, 1'b0);
    ck32({tag, "_host_rd_data"}, host_rd_data, 32'd0);
    ck1({tag, "_host_wr_ready"}, host_wr_ready, 1'b0);
    ck1({tag, "_busy"}, busy, 1'b0);
    ck1({tag, "_done"}, done, 1'b0);
    ck1({tag, "_error"}, error, 1'b0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    ck1({tag, "_done_seen"}, ok, 1'b1);
  endtask

  task automatic do_save(input int stall_w, input int mode);
    for (int i = 0; i < NW; i++) exp_rd.push_back(mem[i]);
    rd_mode    = mode;
    stall_word = stall_w;
    stall_left = (stall_w >= 0) ? 5 : 0;
    rd_base    = rd_cnt;
    save_start = 1'b1;
    tick(1);
    save_start = 1'b0;
  endtask

  logic [31:0] ld_words [NW];

  task automatic issue_word(input int idx, input logic [31:0] w, output bit ok);
    int gap;
    gap = $urandom_range(0, 3);
    host_wr_valid = 1'b0;
    host_wr_data  = $urandom;
    tick(gap);
    host_wr_valid = 1'b1;
    host_wr_data  = w;
    exp_wr.push_back({AW'(idx), w});
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (host_wr_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    host_wr_valid = 1'b0;
    ck1("wr_handshake", ok, 1'b1);
  endtask

  task automatic do_load(input int n, input bit fixed);
    bit ok;
    logic [31:0] w;
    rstn_seen  = 1'b0;
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      w = fixed ? (32'hDEAD_0000 + i) : $urandom;
      ld_words[i] = w;
      issue_word(i, w, ok);
      if (!ok) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, w0, r0, k;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 32'hA000_0000 + i;
      wmem[i] = 32'd0;
    end

    // Reset state.
    reset = 1'b1;
    tick(3);
    check_reset_vals("reset");
    reset = 1'b0;
    tick(2);

    // Save, host always ready.
    d0 = done_cnt; w0 = wren_cnt;
    do_save(-1, 0);
    wait_done("save", 300);
    ck1("save_halt_low", ss_halt, 1'b0);
    ck1("save_busy_low", busy, 1'b0);
    ckint("save_words_left", exp_rd.size(), 0);
    ckint("save_done_pulses", done_cnt - d0, 1);
    ckint("save_no_writes", wren_cnt - w0, 0);
    tick(2);

    // Save with random data, random ready and a long stall on word 2.
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    d0 = done_cnt; r0 = rd_cnt;
    do_save(2, 1);
    wait_done("bp_save", 600);
    ckint("bp_words_left", exp_rd.size(), 0);
    ckint("bp_word_count", rd_cnt - r0, NW);
    ckint("bp_done_pulses", done_cnt - d0, 1);
    rd_mode = 0; stall_word = -1;
    tick(2);

    // Load DEAD0000.. with gaps; host valid is raised before the core is halted.
    d0 = done_cnt; w0 = wren_cnt; r0 = rstn_cnt;
    do_load(NW, 1'b1);
    wait_done("load", 300);
    ckint("load_wren_pulses", wren_cnt - w0, NW);
    ckint("load_bus_reset_pulses", rstn_cnt - r0, 1);
    ckint("load_done_pulses", done_cnt - d0, 1);
    ckint("load_writes_left", exp_wr.size(), 0);
    for (int i = 0; i < NW; i++) ck32("load_core_word", wmem[i], ld_words[i]);
    ck1("load_halt_low", ss_halt, 1'b0);
    tick(2);

    // Halt timeout: core never acknowledges.
    ready_en = 1'b0;
    d0 = done_cnt; e0 = err_cnt; w0 = wren_cnt;
    save_start = 1'b1;
    @(posedge clk);
    #1;
    save_start = 1'b0;
    k = 0;
    for (int i = 1; i <= 4 * HT; i++) begin
      @(posedge clk);
      #1;
      if (error === 1'b1) begin
        k = i;
        break;
      end
    end
    ckint("timeout_latency", k, HT);
    ck1("timeout_busy_low", busy, 1'b0);
    ck1("timeout_halt_low", ss_halt, 1'b0);
    tick(1);
    ck1("timeout_error_one_cycle", error, 1'b0);
    ckint("timeout_error_pulses", err_cnt - e0, 1);
    ckint("timeout_no_done", done_cnt - d0, 0);
    ckint("timeout_no_writes", wren_cnt - w0, 0);
    ready_en = 1'b1;
    tick(2);

    // Simultaneous starts: save wins; a later load_start while busy is ignored.
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    for (int i = 0; i < NW; i++) exp_rd.push_back(mem[i]);
    d0 = done_cnt; w0 = wren_cnt;
    save_start = 1'b1;
    load_start = 1'b1;
    tick(1);
    save_start = 1'b0;
    load_start = 1'b0;
    tick(4);
    load_start = 1'b1;
    tick(1);
    load_start = 1'b0;
    wait_done("both", 300);
    tick(10);
    ckint("both_done_pulses", done_cnt - d0, 1);
    ckint("both_no_writes", wren_cnt - w0, 0);
    ckint("both_words_left", exp_rd.size(), 0);
    ck1("both_busy_low", busy, 1'b0);

    // Reset in the middle of a load, then a full load.
    w0 = wren_cnt;
    do_load(2, 1'b0);
    tick(1);
    ckint("midrst_writes_before", wren_cnt - w0, 2);
    reset = 1'b1;
    tick(1);
    check_reset_vals("midrst");
    reset = 1'b0;
    tick(3);
    d0 = done_cnt; w0 = wren_cnt;
    do_load(NW, 1'b0);
    wait_done("reload", 300);
    ckint("reload_wren_pulses", wren_cnt - w0, NW);
    ckint("reload_done_pulses", done_cnt - d0, 1);
    ckint("reload_writes_left", exp_wr.size(), 0);
    for (int i = 0; i < NW; i++) ck32("reload_core_word", wmem[i], ld_words[i]);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/savestate_controller.md
Name: savestate_controller

Overview:
- Initiator side of the core savestate bus; the CPU register file and peripherals are the responders.
- Pauses the core, then performs one of two operations:
  - Save: walks ss_bus_addr 0..NUM_WORDS-1 and streams ss_bus_out words to the host.
  - Load: accepts host words and writes them into the core through ss_bus_in/ss_bus_wren.
- Sits at top level between the host bridge (APF/MiSTer savestate FIFO) and the cpu instance.

Parameters:
- NUM_WORDS, 16, number of 32-bit state words per savestate (addresses 0..NUM_WORDS-1).
- ADDR_WIDTH, 8, width of ss_bus_addr.
- READ_LATENCY, 1, cycles from ss_bus_addr change to valid ss_bus_out (1..3).
- HALT_TIMEOUT, 4096, max cycles waiting for ss_ready before aborting.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- save_start  input  1  single-cycle pulse; begin save
- load_start  input  1  single-cycle pulse; begin load
- host_rd_data  output  32  save word to host
- host_rd_valid  output  1  host_rd_data valid
- host_rd_ready  input  1  host accepts word
- host_wr_data  input  32  load word from host
- host_wr_valid  input  1  host_wr_data valid
- host_wr_ready  output  1  controller accepts word
- ss_halt  output  1  request core pause
- ss_ready  input  1  core paused at instruction boundary
- ss_bus_addr  output  ADDR_WIDTH  responder address
- ss_bus_in  output  32  write data to core
- ss_bus_wren  output  1  write strobe to core
- ss_bus_reset_n  output  1  active-low savestate bus reset
- ss_bus_out  input  32  read data from core
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse on success
- error  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset values:
  - ss_halt=0, ss_bus_addr=0, ss_bus_in=0, ss_bus_wren=0, ss_bus_reset_n=1.
  - host_rd_valid=0, host_rd_data=0, host_wr_ready=0.
  - busy=0, done=0, error=0; FSM in IDLE; counters cleared.
- States: IDLE, HALT_WAIT, SAVE_ADDR, SAVE_WAIT, SAVE_OUT, LOAD_WAIT, LOAD_WRITE, FINISH.
- IDLE:
  - save_start -> HALT_WAIT (op=save).
  - load_start -> HALT_WAIT (op=load).
  - If both are high in the same cycle, save wins and load is ignored.
  - Starts are ignored while busy.
  - busy is high in every state except IDLE.
- HALT_WAIT:
  - ss_halt=1; timeout counter increments each cycle.
  - ss_ready=1 -> clear address counter, then SAVE_ADDR or LOAD_WAIT.
  - Counter reaching HALT_TIMEOUT-1 without ss_ready -> error pulse, ss_halt=0, IDLE.
- ss_halt stays 1 from HALT_WAIT through FINISH. It drops the cycle FINISH exits.
- For the load op only: ss_bus_reset_n=0 for exactly one cycle, on the cycle ss_ready is first sampled high in HALT_WAIT.
- Save path:
  - SAVE_ADDR: drive ss_bus_addr=count.
  - SAVE_WAIT: wait READ_LATENCY cycles, then register ss_bus_out into host_rd_data.
  - SAVE_OUT: host_rd_valid=1 until the host_rd_valid & host_rd_ready handshake. host_rd_data is stable while valid and not ready.
  - After the handshake: count==NUM_WORDS-1 -> FINISH; otherwise count+1 -> SAVE_ADDR.
- Load path:
  - LOAD_WAIT: host_wr_ready=1.
  - On host_wr_valid & host_wr_ready: latch ss_bus_in=host_wr_data, ss_bus_addr=count -> LOAD_WRITE.
  - LOAD_WRITE: ss_bus_wren=1 for exactly one cycle. host_wr_ready=0 in this state.
  - Then: last word -> FINISH; otherwise count+1 -> LOAD_WAIT.
- FINISH: done=1 for one cycle, ss_bus_wren=0 -> IDLE.
- Counter width is ADDR_WIDTH and never wraps. Termination is decided on count==NUM_WORDS-1, not on overflow.
- No timeout applies during transfer; host stalls are unbounded.
- Reset mid-operation returns to the reset values the next cycle. A partial load is not rolled back.
- host_wr_valid while not in LOAD_WAIT is ignored: no data is consumed.

Decomposition:
- Shared package `types` gains typedef enum ss_state_t for the FSM states and typedef enum ss_op_t {SS_OP_SAVE, SS_OP_LOAD}.
- One sub-module, ss_timeout_counter: a generic saturating counter with clear/enable and a terminal-count output, used for both halt timeout and read latency.
- Everything else stays inline.

Test Plan:
- Save, NUM_WORDS=4: ss_ready high 3 cycles after the halt request; responder model returns 32'hA000_0000+addr. Host receives A0000000..A0000003 in order; one done pulse; ss_halt low afterwards.
- Save with backpressure: host_rd_ready low for 5 cycles on word 2. host_rd_data holds A0000002 stable; no skipped or duplicated words.
- Load, NUM_WORDS=4: host supplies DEAD0000..DEAD0003 with valid gaps. Exactly 4 single-cycle wren pulses at addr 0..3 with matching ss_bus_in; one ss_bus_reset_n low pulse before the first write.
- Timeout, HALT_TIMEOUT=16: ss_ready held 0. error pulses 16 cycles after start; busy and ss_halt drop; no bus writes occur.
- Simultaneous save_start and load_start: save runs. load_start during busy is ignored; done count is 1.
- Reset asserted mid-load after word 1: all outputs at reset values the next cycle; a subsequent load completes normally.
